// File: rtl/bcd_disp_pkg.sv
// Shared constants, types and small helpers for the four-digit BCD display scanner.
package bcd_disp_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef logic [1:0] digit_idx_t;

    localparam logic [NUM_DIGITS-1:0] DIGIT0_EN = 4'b0001;

    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input digit_idx_t idx);
        return DIGIT0_EN << idx;
    endfunction

    function automatic logic [DIGIT_W-1:0] nibble_sel(
        input logic [NUM_DIGITS*DIGIT_W-1:0] value,
        input digit_idx_t                     idx
    );
        logic [DIGIT_W-1:0] nib;
        case (idx)
            2'd0:    nib = value[3:0];
            2'd1:    nib = value[7:4];
            2'd2:    nib = value[11:8];
            2'd3:    nib = value[15:12];
            default: nib = 4'd0;
        endcase
        return nib;
    endfunction

    // A slot is a leading zero when it and every more-significant digit are zero.
    function automatic logic is_leading_zero(
        input logic [NUM_DIGITS*DIGIT_W-1:0] value,
        input digit_idx_t                     idx
    );
        logic lz;
        case (idx)
            2'd1:    lz = (value[15:4] == 12'h000);
            2'd2:    lz = (value[15:8] == 8'h00);
            2'd3:    lz = (value[15:12] == 4'h0);
            default: lz = 1'b0;
        endcase
        return lz;
    endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Free-running divider: tick is high for one cycle out of every DIV (every cycle when DIV=1).
module refresh_prescaler
    import bcd_disp_pkg::*;
#(
    parameter int DIV = 1000
)
(
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;

    // Next count: wrap to zero after the terminal value.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (cnt_r == LAST) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + CW'(1);
        end
    end

    // Counter and a registered tick that is high while the count sits at its terminal value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
            tick  <= (LAST == '0);
        end else begin
            cnt_r <= cnt_nxt_s;
            tick  <= (cnt_nxt_s == LAST);
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed four-digit BCD display scanner with a frame-synchronous double buffer.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 1000
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] bcd_in,
    output logic [DIGIT_W-1:0]            bcd_out,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic                          blank,
    output logic                          frame_start,
    output logic                          digit_invalid
);

    logic                          tick_s;
    logic                          wrap_s;
    digit_idx_t                    idx_r;
    digit_idx_t                    idx_nxt_s;
    logic [NUM_DIGITS*DIGIT_W-1:0] pending_r;
    logic [NUM_DIGITS*DIGIT_W-1:0] pending_nxt_s;
    logic [NUM_DIGITS*DIGIT_W-1:0] active_r;
    logic [NUM_DIGITS*DIGIT_W-1:0] active_nxt_s;
    logic [DIGIT_W-1:0]            nib_s;
    logic                          blank_s;
    logic [NUM_DIGITS-1:0]         en_s;

    refresh_prescaler #(
        .DIV  (REFRESH_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Next scan state; outputs are derived from the next index and next active value
    // so that every output register switches on the same edge as the index.
    always_comb begin
        wrap_s        = tick_s && (idx_r == 2'd3);
        idx_nxt_s     = tick_s ? (idx_r + 2'd1) : idx_r;
        pending_nxt_s = load ? bcd_in : pending_r;
        active_nxt_s  = wrap_s ? pending_nxt_s : active_r;
        nib_s         = nibble_sel(active_nxt_s, idx_nxt_s);
`ifdef LEADING_ZERO_BLANK_EN
        blank_s       = is_leading_zero(active_nxt_s, idx_nxt_s);
`else
        blank_s       = 1'b0;
`endif
        if (blank_s) begin
            en_s = 4'b0000;
        end else begin
            en_s = digit_onehot(idx_nxt_s);
        end
    end

    // Scan index, double buffer and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r         <= 2'd0;
            pending_r     <= 16'h0000;
            active_r      <= 16'h0000;
            bcd_out       <= 4'd0;
            digit_en      <= DIGIT0_EN;
            blank         <= 1'b0;
            frame_start   <= 1'b0;
            digit_invalid <= 1'b0;
        end else begin
            idx_r         <= idx_nxt_s;
            pending_r     <= pending_nxt_s;
            active_r      <= active_nxt_s;
            bcd_out       <= nib_s;
            digit_en      <= en_s;
            blank         <= blank_s;
            frame_start   <= wrap_s;
            digit_invalid <= (nib_s > BCD_MAX);
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomised and directed bench for bcd_display_scanner at REFRESH_DIV=4 and REFRESH_DIV=1.
module tb_bcd_display_scanner;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4 = 1'b1;
    logic        load4 = 1'b0;
    logic [15:0] bcd4 = 16'h0000;
    logic [3:0]  bcd_out4;
    logic [3:0]  digit_en4;
    logic        blank4, frame_start4, digit_invalid4;

    logic        rst1 = 1'b1;
    logic        load1 = 1'b0;
    logic [15:0] bcd1 = 16'h0000;
    logic [3:0]  bcd_out1;
    logic [3:0]  digit_en1;
    logic        blank1, frame_start1, digit_invalid1;

    bcd_display_scanner #(.REFRESH_DIV(4)) dut4 (
        .clk(clk), .rst(rst4), .load(load4), .bcd_in(bcd4),
        .bcd_out(bcd_out4), .digit_en(digit_en4), .blank(blank4),
        .frame_start(frame_start4), .digit_invalid(digit_invalid4)
    );

    bcd_display_scanner #(.REFRESH_DIV(1)) dut1 (
        .clk(clk), .rst(rst1), .load(load1), .bcd_in(bcd1),
        .bcd_out(bcd_out1), .digit_en(digit_en1), .blank(blank1),
        .frame_start(frame_start1), .digit_invalid(digit_invalid1)
    );

    wire [10:0] obs4 = {bcd_out4, digit_en4, blank4, frame_start4, digit_invalid4};
    wire [10:0] obs1 = {bcd_out1, digit_en1, blank1, frame_start1, digit_invalid1};

    int total = 0;
    int bad   = 0;

    // Model state: e = clock edges since reset released, last = newest loaded value,
    // shown = value latched for the frame currently on display.
    int          e4 = 0;
    logic [15:0] last4 = 16'h0000;
    logic [15:0] shown4 = 16'h0000;
    int          e1 = 0;
    logic [15:0] last1 = 16'h0000;
    logic [15:0] shown1 = 16'h0000;

    function automatic logic [10:0] exp_out(input int div, input int e, input logic [15:0] v);
        int         s;
        logic [3:0] nib;
        logic       blk;
        logic [3:0] en;
        logic       fs;
        s   = (e / div) % 4;
        nib = v[4*s +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blk = (s > 0) && ((v >> (4*s)) == 16'h0000);
`else
        blk = 1'b0;
`endif
        en  = blk ? 4'b0000 : (4'b0001 << s);
        fs  = (e > 0) && ((e % (4*div)) == 0);
        return {nib, en, blk, fs, (nib > 4'd9)};
    endfunction

    task automatic step4(input logic ld, input logic [15:0] v, input logic r);
        load4 = ld; bcd4 = v; rst4 = r;
        @(posedge clk);
        if (r) begin
            e4 = 0; last4 = 16'h0000; shown4 = 16'h0000;
        end else begin
            if (ld) last4 = v;
            e4++;
            if (e4 % 16 == 0) shown4 = last4;
        end
        @(negedge clk);
        load4 = 1'b0; rst4 = 1'b0;
    endtask

    task automatic step1(input logic ld, input logic [15:0] v, input logic r);
        load1 = ld; bcd1 = v; rst1 = r;
        @(posedge clk);
        if (r) begin
            e1 = 0; last1 = 16'h0000; shown1 = 16'h0000;
        end else begin
            if (ld) last1 = v;
            e1++;
            if (e1 % 4 == 0) shown1 = last1;
        end
        @(negedge clk);
        load1 = 1'b0; rst1 = 1'b0;
    endtask

    task automatic test_reset();
        step4(1'b1, 16'hFFFF, 1'b1);
        step4(1'b0, 16'h0000, 1'b1);
        total++;
        if (obs4 !== 11'b0000_0001_0_0_0) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", obs4, 11'b0000_0001_0_0_0);
        end
        total++;
        if (obs4 !== exp_out(4, e4, shown4)) begin
            bad++;
            $display("FAIL reset_model: got %h want %h", obs4, exp_out(4, e4, shown4));
        end
    endtask

    task automatic test_frame_1234();
        step4(1'b1, 16'h1234, 1'b0);
        for (int i = 0; i < 48; i++) begin
            total++;
            if (obs4 !== exp_out(4, e4, shown4)) begin
                bad++;
                $display("FAIL frame_1234 e=%0d: got %h want %h", e4, obs4, exp_out(4, e4, shown4));
            end
            step4(1'b0, 16'h0000, 1'b0);
        end
        // Directed spot check: frame showing 1234, slot 2 lit with digit 2.
        while ((e4 / 4) % 4 != 2) step4(1'b0, 16'h0000, 1'b0);
        total++;
        if ({bcd_out4, digit_en4} !== {4'd2, 4'b0100}) begin
            bad++;
            $display("FAIL frame_1234_slot2: got %h/%b want 2/0100", bcd_out4, digit_en4);
        end
    endtask

    task automatic test_midframe_load();
        step4(1'b1, 16'h5678, 1'b0);
        for (int i = 0; i < 40; i++) begin
            total++;
            if (obs4 !== exp_out(4, e4, shown4)) begin
                bad++;
                $display("FAIL midframe_load e=%0d: got %h want %h", e4, obs4, exp_out(4, e4, shown4));
            end
            step4(1'b0, 16'h0000, 1'b0);
        end
    endtask

    task automatic test_load_on_wrap();
        while ((e4 + 1) % 16 != 0) step4(1'b0, 16'h0000, 1'b0);
        step4(1'b1, 16'h0909, 1'b0);
        total++;
        if ({bcd_out4, frame_start4} !== {4'd9, 1'b1}) begin
            bad++;
            $display("FAIL load_on_wrap_first: got %h/%b want 9/1", bcd_out4, frame_start4);
        end
        for (int i = 0; i < 20; i++) begin
            total++;
            if (obs4 !== exp_out(4, e4, shown4)) begin
                bad++;
                $display("FAIL load_on_wrap e=%0d: got %h want %h", e4, obs4, exp_out(4, e4, shown4));
            end
            step4(1'b0, 16'h0000, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        step4(1'b1, 16'h1111, 1'b0);
        step4(1'b1, 16'h2222, 1'b0);
        step4(1'b1, 16'h3333, 1'b0);
        for (int i = 0; i < 36; i++) begin
            total++;
            if (obs4 !== exp_out(4, e4, shown4)) begin
                bad++;
                $display("FAIL back_to_back e=%0d: got %h want %h", e4, obs4, exp_out(4, e4, shown4));
            end
            step4(1'b0, 16'h0000, 1'b0);
        end
    endtask

    task automatic test_patterns();
        logic [15:0] pats [5] = '{16'h0050, 16'h0000, 16'h00A0, 16'h0F00, 16'h9999};
        for (int p = 0; p < 5; p++) begin
            step4(1'b1, pats[p], 1'b0);
            for (int i = 0; i < 36; i++) begin
                total++;
                if (obs4 !== exp_out(4, e4, shown4)) begin
                    bad++;
                    $display("FAIL pattern_%h e=%0d: got %h want %h", pats[p], e4, obs4, exp_out(4, e4, shown4));
                end
                step4(1'b0, 16'h0000, 1'b0);
            end
        end
    endtask

    task automatic test_reset_midframe();
        while ((e4 / 4) % 4 != 2) step4(1'b0, 16'h0000, 1'b0);
        step4(1'b1, 16'h4321, 1'b0);
        step4(1'b0, 16'h0000, 1'b1);
        total++;
        if ({bcd_out4, digit_en4} !== {4'd0, 4'b0001}) begin
            bad++;
            $display("FAIL reset_midframe: got %h/%b want 0/0001", bcd_out4, digit_en4);
        end
        for (int i = 0; i < 40; i++) begin
            step4(1'b0, 16'h0000, 1'b0);
            total++;
            if (obs4 !== exp_out(4, e4, shown4)) begin
                bad++;
                $display("FAIL reset_discard e=%0d: got %h want %h", e4, obs4, exp_out(4, e4, shown4));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            step4(($urandom % 8) == 0, 16'($urandom), ($urandom % 150) == 0);
            total++;
            if (obs4 !== exp_out(4, e4, shown4)) begin
                bad++;
                $display("FAIL random4 e=%0d: got %h want %h", e4, obs4, exp_out(4, e4, shown4));
            end
        end
    endtask

    task automatic test_div1();
        step1(1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 300; i++) begin
            step1(($urandom % 3) == 0, 16'($urandom), ($urandom % 100) == 0);
            total++;
            if (obs1 !== exp_out(1, e1, shown1)) begin
                bad++;
                $display("FAIL div1 e=%0d: got %h want %h", e1, obs1, exp_out(1, e1, shown1));
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_frame_1234();
        test_midframe_load();
        test_load_on_wrap();
        test_back_to_back();
        test_patterns();
        test_reset_midframe();
        test_random();
        test_div1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 1000, meaning clock cycles per digit slot (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-004 SHALL have port load, input, 1, meaning capture bcd_in this cycle.
REQ-005 SHALL have port bcd_in, input, 16, meaning four BCD digits; [3:0] is digit 0 (least significant), [15:12] is digit 3.
REQ-006 SHALL have port bcd_out, output, 4, meaning the BCD nibble of the currently scanned digit, fed to the downstream 7-segment decoder.
REQ-007 SHALL have port digit_en, output, 4, meaning one-hot, active-high enable of the currently lit digit.
REQ-008 SHALL have port blank, output, 1, meaning the current slot is suppressed (digit_en is all-zero).
REQ-009 SHALL have port frame_start, output, 1, meaning a one-cycle pulse when the scan returns to digit 0.
REQ-010 SHALL have port digit_invalid, output, 1, meaning the current bcd_out is greater than 9.

Function
REQ-011 SHALL count a prescaler 0..REFRESH_DIV-1, asserting an internal tick at REFRESH_DIV-1 and then wrapping to 0.
- With REFRESH_DIV=1, tick SHALL be asserted every cycle.
REQ-012 SHALL advance the digit index 0->1->2->3->0 on each tick and hold it otherwise.
REQ-013 SHALL register all outputs; they SHALL reflect the new index in the cycle after the tick edge, with no glitching between slots.
REQ-014 SHALL double-buffer the value.
- load writes bcd_in into a pending register.
- Pending SHALL transfer to the active register only on the tick that wraps the index from 3 to 0.
REQ-015 SHALL, when load coincides with the 3->0 tick, write bcd_in into both the pending and active registers in that cycle.
REQ-016 SHALL, when load is asserted on consecutive cycles, keep only the last value for the next frame (no queuing).
REQ-017 SHALL drive bcd_out from the active register nibble selected by the index, and SHALL hold the whole frame constant (no tearing).
REQ-018 SHALL pass nibbles 10..15 through unchanged, with digit_invalid=1 for that slot.
REQ-019 SHALL pulse frame_start for exactly one cycle, coincident with the outputs first showing digit 0 of a new frame.
REQ-020 SHALL give a load-to-display latency of at most 4*REFRESH_DIV+1 cycles.

Reset
REQ-021 SHALL, with rst high, set the prescaler to 0, the index to 0, pending to 0 and active to 0.
REQ-022 SHALL, with rst high, drive bcd_out=0, digit_en=4'b0001, blank=0, frame_start=0 and digit_invalid=0.
REQ-023 SHALL give rst priority over load and tick; an assertion mid-frame SHALL abort the scan and discard the pending value.
REQ-024 SHALL restart the prescaler from 0 on the first cycle after rst deasserts.

Configuration
REQ-025 SHALL use macro LEADING_ZERO_BLANK_EN.
- When defined: digit k (k=3..1) SHALL be blanked if it and all more-significant active digits are 0.
- A blanked slot SHALL drive digit_en=0 and blank=1, with bcd_out still driven.
- Digit 0 SHALL never be blanked.
REQ-026 SHALL, when LEADING_ZERO_BLANK_EN is undefined, tie blank to 0 and never suppress digit_en.

Structure
REQ-027 SHALL place the following in shared package bcd_disp_pkg:
- NUM_DIGITS=4, DIGIT_W=4, BCD_MAX=9;
- typedef digit_idx_t (2 bits);
- constant DIGIT0_EN=4'b0001.
REQ-028 SHALL implement the prescaler as sub-module refresh_prescaler (parameter DIV; ports clk, rst, tick); scan and buffer logic stay in bcd_display_scanner.

Verification
REQ-029 SHALL cover: REFRESH_DIV=4, rst, load 16'h1234 -> after the next 3->0 wrap, bcd_out sequence 4,3,2,1 with digit_en 0001,0010,0100,1000, each held 4 cycles.
REQ-030 SHALL cover: load 16'h5678 mid-frame while showing 16'h1234 -> the current frame finishes with 1234 digits; the next frame shows 8,7,6,5.
REQ-031 SHALL cover: load asserted on the same cycle as the 3->0 tick with 16'h0909 -> the new frame shows 9,0,9,0 immediately.
REQ-032 SHALL cover: LEADING_ZERO_BLANK_EN defined, load 16'h0050 -> slots 3,2 have blank=1 and digit_en=0; slots 1,0 are lit with bcd_out 5,0. Load 16'h0000 -> only digit 0 lit.
REQ-033 SHALL cover: load 16'h00A0 -> slot 1 gives bcd_out=4'hA and digit_invalid=1; other slots give digit_invalid=0.
REQ-034 SHALL cover: rst asserted at index 2 with a pending load -> the next cycle gives bcd_out=0 and digit_en=0001; the pending value is never displayed; REFRESH_DIV=1 advances the digit every cycle.
